// File: rtl/lstm_param_loader.sv
// Byte-serial LSTM parameter loader: packs bytes into words and issues addressed writes per region.
// Latency: 1 cycle from a word's last byte to oWr_en. Backpressure: none, a valid byte is always consumed.
// Optional LOAD_CHECKSUM_EN adds a per-region byte checksum (oChecksum / oChecksum_valid).
module lstm_param_loader #(
    parameter int NUM_REGIONS = 6,
    parameter int TYPE_W      = 3,
    parameter int IDLE_TYPE   = 7,
    parameter int WORD_BYTES  = 4,
    parameter int LEN_W       = 17,
    parameter logic [NUM_REGIONS*LEN_W-1:0] REGION_LEN =
        {17'd128, 17'd1024, 17'd256, 17'd32768, 17'd32, 17'd512}
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    iInit_valid,
    input  logic [TYPE_W-1:0]       iInit_type,
    input  logic [7:0]              iInit_data,
    input  logic                    iClear,
    output logic                    oWr_en,
    output logic [TYPE_W-1:0]       oWr_region,
    output logic [LEN_W-1:0]        oWr_addr,
    output logic [8*WORD_BYTES-1:0] oWr_data,
    output logic                    oBusy,
    output logic [NUM_REGIONS-1:0]  oRegion_done,
    output logic                    oAll_done,
    output logic [1:0]              oErr
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [15:0]             oChecksum,
    output logic                    oChecksum_valid
`endif
);

    localparam int DW     = 8 * WORD_BYTES;
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                   state_q, state_d;
    logic [TYPE_W-1:0]        cur_type_q, cur_type_d;
    logic [LEN_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0]         word_idx_q, word_idx_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [DW-1:0]            pack_q, pack_d;
    logic                     wr_en_q, wr_en_d;
    logic [TYPE_W-1:0]        wr_region_q, wr_region_d;
    logic [LEN_W-1:0]         wr_addr_q, wr_addr_d;
    logic [DW-1:0]            wr_data_q, wr_data_d;
    logic                     busy_q, busy_d;
    logic [NUM_REGIONS-1:0]   region_done_q, region_done_d;
    logic [1:0]               err_q, err_d;

    logic                     start, take, abort, last, full;
    logic [TYPE_W-1:0]        byte_type;
    logic [LEN_W-1:0]         cnt_next;
    logic [NUM_REGIONS-1:0]   type_oh;
    int                       filled;

    function automatic logic [LEN_W-1:0] len_of(input logic [TYPE_W-1:0] t);
        len_of = '0;
        for (int r = 0; r < NUM_REGIONS; r++)
            if (t == TYPE_W'(r)) len_of = REGION_LEN[r*LEN_W +: LEN_W];
    endfunction

    function automatic logic [NUM_REGIONS-1:0] onehot(input logic [TYPE_W-1:0] t);
        onehot = '0;
        for (int r = 0; r < NUM_REGIONS; r++)
            if (t == TYPE_W'(r)) onehot[r] = 1'b1;
    endfunction

    // Left-align a partial word so the first byte lands in the MSB lane; low lanes shift in as zero.
    function automatic logic [DW-1:0] align(input logic [DW-1:0] p, input int n);
        align = p << (8 * (WORD_BYTES - n));
    endfunction

    always_comb begin
        state_d       = state_q;
        cur_type_d    = cur_type_q;
        byte_cnt_d    = byte_cnt_q;
        word_idx_d    = word_idx_q;
        lane_d        = lane_q;
        pack_d        = pack_q;
        wr_en_d       = 1'b0;
        wr_region_d   = wr_region_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        region_done_d = iClear ? '0 : region_done_q;
        err_d         = iClear ? 2'd0 : err_q;
        start         = 1'b0;
        take          = 1'b0;
        abort         = 1'b0;
        last          = 1'b0;
        full          = 1'b0;
        byte_type     = cur_type_q;
        cnt_next      = byte_cnt_q;
        type_oh       = '0;
        filled        = 0;

        if (iInit_valid) begin
            if (state_q == IDLE) begin
                if (int'(iInit_type) < NUM_REGIONS) begin
                    start = 1'b1;
                end else if (iInit_type != TYPE_W'(IDLE_TYPE) && err_d == 2'd0) begin
                    err_d = 2'd1;
                end
            end else if (iInit_type == cur_type_q) begin
                take = 1'b1;
            end else if (iInit_type != TYPE_W'(IDLE_TYPE)) begin
                // Idle-type filler is harmless mid-region; any other type aborts the region.
                abort = 1'b1;
            end
        end

        if (start || take) begin
            byte_type = start ? iInit_type : cur_type_q;
            type_oh   = onehot(byte_type);
            cnt_next  = start ? LEN_W'(1) : byte_cnt_q + LEN_W'(1);
            filled    = start ? 1 : int'(lane_q) + 1;
            full      = (filled == WORD_BYTES);
            last      = (cnt_next == len_of(byte_type));
            pack_d    = (pack_q << 8) | DW'(iInit_data);
            lane_d    = full ? '0 : LANE_W'(filled);
            byte_cnt_d = cnt_next;
            if (start) begin
                cur_type_d    = iInit_type;
                region_done_d = region_done_d & ~type_oh;
                word_idx_d    = '0;
                state_d       = LOAD;
            end
            if (full || last) begin
                wr_en_d     = 1'b1;
                wr_region_d = byte_type;
                wr_addr_d   = start ? '0 : word_idx_q;
                wr_data_d   = align(pack_d, filled);
                word_idx_d  = (start ? '0 : word_idx_q) + LEN_W'(1);
            end
            if (last) begin
                region_done_d = region_done_d | type_oh;
                state_d       = IDLE;
                byte_cnt_d    = '0;
                word_idx_d    = '0;
                lane_d        = '0;
            end
        end

        if (abort) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
            word_idx_d = '0;
            lane_d     = '0;
            if (err_d == 2'd0) err_d = 2'd2;
        end

        busy_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cur_type_q    <= '0;
            byte_cnt_q    <= '0;
            word_idx_q    <= '0;
            lane_q        <= '0;
            pack_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_region_q   <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            region_done_q <= '0;
            err_q         <= 2'd0;
        end else begin
            state_q       <= state_d;
            cur_type_q    <= cur_type_d;
            byte_cnt_q    <= byte_cnt_d;
            word_idx_q    <= word_idx_d;
            lane_q        <= lane_d;
            pack_q        <= pack_d;
            wr_en_q       <= wr_en_d;
            wr_region_q   <= wr_region_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            region_done_q <= region_done_d;
            err_q         <= err_d;
        end
    end

    assign oWr_en       = wr_en_q;
    assign oWr_region   = wr_region_q;
    assign oWr_addr     = wr_addr_q;
    assign oWr_data     = wr_data_q;
    assign oBusy        = busy_q;
    assign oRegion_done = region_done_q;
    assign oAll_done    = &region_done_q;
    assign oErr         = err_q;

`ifdef LOAD_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    logic        csum_vld_q, csum_vld_d;

    always_comb begin
        csum_d     = csum_q;
        csum_vld_d = 1'b0;
        if (start)
            csum_d = 16'(iInit_data);
        else if (take)
            csum_d = csum_q + 16'(iInit_data);
        else if (abort)
            csum_d = '0;
        if ((start || take) && last)
            csum_vld_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csum_q     <= '0;
            csum_vld_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            csum_vld_q <= csum_vld_d;
        end
    end

    assign oChecksum       = csum_q;
    assign oChecksum_valid = csum_vld_q;
`else
    // Checksum build option disabled: no accumulator.
`endif

endmodule

// File: tb/tb_lstm_param_loader.sv
module tb_lstm_param_loader;
    localparam int NR = 6;
    localparam int TW = 3;
    localparam int WB = 4;
    localparam int LW = 17;
    localparam int DW = 32;
    localparam logic [NR*LW-1:0] RL = {17'd128, 17'd64, 17'd40, 17'd1, 17'd32, 17'd6};

    int lens [NR] = '{6, 32, 1, 40, 64, 128};

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          iInit_valid = 1'b0;
    logic [TW-1:0] iInit_type = '0;
    logic [7:0]    iInit_data = '0;
    logic          iClear = 1'b0;
    logic          oWr_en;
    logic [TW-1:0] oWr_region;
    logic [LW-1:0] oWr_addr;
    logic [DW-1:0] oWr_data;
    logic          oBusy;
    logic [NR-1:0] oRegion_done;
    logic          oAll_done;
    logic [1:0]    oErr;
`ifdef LOAD_CHECKSUM_EN
    logic [15:0]   oChecksum;
    logic          oChecksum_valid;
`endif

    lstm_param_loader #(
        .NUM_REGIONS(NR), .TYPE_W(TW), .IDLE_TYPE(7), .WORD_BYTES(WB),
        .LEN_W(LW), .REGION_LEN(RL)
    ) dut (
        .clk(clk), .resetn(resetn),
        .iInit_valid(iInit_valid), .iInit_type(iInit_type), .iInit_data(iInit_data),
        .iClear(iClear),
        .oWr_en(oWr_en), .oWr_region(oWr_region), .oWr_addr(oWr_addr), .oWr_data(oWr_data),
        .oBusy(oBusy), .oRegion_done(oRegion_done), .oAll_done(oAll_done), .oErr(oErr)
`ifdef LOAD_CHECKSUM_EN
        , .oChecksum(oChecksum), .oChecksum_valid(oChecksum_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          region;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q [$];
    logic [15:0] cs_q [$];
    int          total = 0;
    int          bad = 0;

    // Reference model state: what a loader following the stream rules should hold.
    bit          m_active;
    int          m_type;
    int          m_cnt;
    int          m_widx;
    int          m_sum;
    logic [7:0]  m_buf [$];
    logic [NR-1:0] m_done;
    logic [1:0]  m_err;

    logic [31:0] last_data;
    int          last_addr;
    logic [15:0] last_cs;
    bit          prev_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 0; m_type = 0; m_cnt = 0; m_widx = 0; m_sum = 0;
        m_buf.delete(); m_done = '0; m_err = 2'd0;
    endfunction

    function automatic void push_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < m_buf.size(); i++) w[31-8*i -: 8] = m_buf[i];
        exp_q.push_back('{m_type, m_widx, w});
        m_widx++;
        m_buf.delete();
    endfunction

    function automatic void take_byte(input logic [7:0] d);
        m_buf.push_back(d);
        m_cnt++;
        m_sum += int'(d);
        if (m_buf.size() == WB || m_cnt == lens[m_type]) push_word();
        if (m_cnt == lens[m_type]) begin
            m_done[m_type] = 1'b1;
            m_active = 0;
            cs_q.push_back(16'(m_sum));
        end
    endfunction

    function automatic void model(input bit v, input int t, input logic [7:0] d, input bit clr);
        if (clr) begin
            m_done = '0;
            m_err = 2'd0;
        end
        if (!v) return;
        if (!m_active) begin
            if (t < NR) begin
                m_active = 1; m_type = t; m_cnt = 0; m_widx = 0; m_sum = 0;
                m_buf.delete();
                m_done[t] = 1'b0;
                take_byte(d);
            end else if (t != 7 && m_err == 2'd0) begin
                m_err = 2'd1;
            end
        end else if (t == m_type) begin
            take_byte(d);
        end else begin
            if (m_err == 2'd0) m_err = 2'd2;
            m_active = 0;
            m_buf.delete();
        end
    endfunction

    task automatic drive(input bit v, input int t, input int d, input bit clr);
        iInit_valid = v;
        iInit_type  = t[TW-1:0];
        iInit_data  = d[7:0];
        iClear      = clr;
        model(v, t, d[7:0], clr);
        @(posedge clk);
        #1;
        iInit_valid = 1'b0;
        iClear      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    // gap: 0 back-to-back, 1 every other cycle, 2 random; base < 0 means random data.
    task automatic send(input int t, input int n, input int gap, input int base);
        for (int i = 0; i < n; i++) begin
            drive(1, t, (base < 0) ? int'($urandom_range(0, 255)) : base + i, 0);
            if (gap == 1) idle(1);
            else if (gap == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
    endtask

    task automatic checkpoint(input string tag);
        idle(3);
        check({tag, " busy"}, 32'(oBusy), 32'(m_active));
        check({tag, " err"}, 32'(oErr), 32'(m_err));
        check({tag, " done"}, 32'(oRegion_done), 32'(m_done));
        check({tag, " all_done"}, 32'(oAll_done), 32'(&m_done));
        check({tag, " pending writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (oWr_en) begin
                check("wr_en back-to-back", 32'(prev_wr), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected write: region %0d addr %0d data 0x%0h, none expected",
                             oWr_region, oWr_addr, oWr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_region", 32'(oWr_region), 32'(e.region));
                    check("wr_addr", 32'(oWr_addr), 32'(e.addr));
                    check("wr_data", oWr_data, e.data);
                end
                last_data = oWr_data;
                last_addr = int'(oWr_addr);
            end
`ifdef LOAD_CHECKSUM_EN
            if (oChecksum_valid) begin
                check("checksum with write", 32'(oWr_en), 32'd1);
                if (cs_q.size() > 0) check("checksum", 32'(oChecksum), 32'(cs_q.pop_front()));
                last_cs = oChecksum;
            end
`endif
        end
        prev_wr = oWr_en;
    end

    initial begin
        int t, o, n;
        model_reset();
        last_data = '0; last_addr = 0; last_cs = '0; prev_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        check("reset wr_en", 32'(oWr_en), 32'd0);
        check("reset wr_data", oWr_data, 32'd0);
        check("reset wr_addr", 32'(oWr_addr), 32'd0);
        check("reset busy", 32'(oBusy), 32'd0);
        check("reset done", 32'(oRegion_done), 32'd0);
        check("reset err", 32'(oErr), 32'd0);

        // Region 1, 0x00..0x1F back to back.
        send(1, 32, 0, 0);
        checkpoint("r1");
        check("r1 done bits", 32'(oRegion_done), 32'h02);
        check("r1 last addr", 32'(last_addr), 32'd7);
        check("r1 last data", last_data, 32'h1C1D1E1F);
`ifdef LOAD_CHECKSUM_EN
        check("r1 checksum", 32'(last_cs), 32'h01F0);
`endif

        // Region 5 with valid low every other cycle; busy must hold through the gaps.
        send(5, 64, 1, 16);
        check("r5 busy mid-load", 32'(oBusy), 32'd1);
        send(5, 64, 1, 80);
        checkpoint("r5");

        // Region 0 (length 6): partial second word is zero padded.
        send(0, 6, 0, 'hA1);
        checkpoint("r0");
        check("r0 last addr", 32'(last_addr), 32'd1);
        check("r0 last data", last_data, 32'hA5A60000);

        // Type switch mid-region on region 3.
        send(3, 10, 0, 'h40);
        drive(1, 4, 'h77, 0);
        checkpoint("abort");
        check("abort err code", 32'(oErr), 32'd2);
        drive(0, 0, 0, 1);
        checkpoint("clear");

        // Bad type then idle-type filler.
        drive(1, 6, 'h11, 0);
        drive(1, 7, 'h22, 0);
        drive(1, 7, 'h33, 0);
        checkpoint("bad type");
        check("bad type err code", 32'(oErr), 32'd1);
        drive(0, 0, 0, 1);

        // Single-byte region 2.
        send(2, 1, 0, 'h5C);
        checkpoint("r2 single");

        // Randomised loads, reloads and aborts.
        for (int k = 0; k < 14; k++) begin
            drive(0, 0, 0, 1);
            t = $urandom_range(0, NR - 1);
            if (lens[t] > 1 && $urandom_range(0, 3) == 0) begin
                n = $urandom_range(1, lens[t] - 1);
                send(t, n, 2, -1);
                o = (t + 1 + $urandom_range(0, NR - 2)) % NR;
                drive(1, o, $urandom_range(0, 255), 0);
            end else begin
                send(t, lens[t], 2, -1);
            end
            checkpoint("random");
        end

        // Load all regions with full lengths.
        drive(0, 0, 0, 1);
        for (int r = 0; r < NR; r++) begin
            send(r, lens[r], 2, -1);
            idle(1);
        end
        checkpoint("all");
        check("all done flag", 32'(oAll_done), 32'd1);

        // iClear coincident with region 0 completing.
        send(0, 5, 0, 'h10);
        drive(1, 0, 'h15, 1);
        checkpoint("clear vs done");
        check("clear vs done bits", 32'(oRegion_done), 32'h01);

        // Asynchronous reset in the middle of region 4.
        send(4, 5, 0, 'h60);
        idle(2);
        resetn = 1'b0;
        model_reset();
        exp_q.delete();
        cs_q.delete();
        #3;
        check("async reset busy", 32'(oBusy), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        checkpoint("after reset");
        check("after reset wr_data", oWr_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
